// File: rtl/enum_type.sv
// rtl/enum_type.sv - shared game engine state/command enumeration
package enum_type;

    typedef enum logic [3:0] {
        NONE,
        INIT,
        WAIT,
        DOWN,
        BAR,
        LEFT,
        RIGHT,
        ROTATE,
        ROTATE_REV,
        DROP,
        HOLD,
        END
    } state_type;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at a pointer
module rr_arbiter #(
    parameter int NSRC = 4,
    parameter int PW   = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NSRC-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            grant_any
);

    // Walk sources from ptr upward with wrap; the first requester found wins
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < NSRC; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NSRC) begin
                idx = idx - NSRC;
            end
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmd_arbiter.sv
// rtl/cmd_arbiter.sv - merges producer commands into one FIFO-ordered engine stream
module cmd_arbiter
    import enum_type::*;
#(
    parameter int NSRC      = 4,
    parameter int QSIZE     = 16,
    parameter int TIMER_SRC = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NSRC-1:0]          req_valid,
    input  state_type [NSRC-1:0]     req_cmd,
    output logic [NSRC-1:0]          req_ready,
    input  state_type                state,
    input  logic                     flush,
    output state_type                control,
    output logic [$clog2(QSIZE):0]   count,
    output logic                     coalesced
);

    localparam int PW = $clog2(NSRC);
    localparam int AW = $clog2(QSIZE);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(QSIZE);

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    state_type       mem_q [QSIZE];
    state_type       mem_d [QSIZE];
    logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   down_q, down_d, bar_q, bar_d;
    logic            coalesced_q, coalesced_d;

    state_type       head;
    state_type       grant_cmd;
    state_type       timer_cmd;
    logic            pop, room, timer_dup, coalesce, push;
    logic [NSRC-1:0] elig, grant;
    logic [PW-1:0]   grant_idx;
    logic            grant_any;

    // Decide who may compete this cycle and how the FIFO moves
    always_comb begin
        head      = (count_q != '0) ? mem_q[rd_q] : NONE;
        pop       = (state == WAIT) && (count_q != '0) && !flush;
        room      = (count_q != FULL_LVL) || pop;
        timer_cmd = req_cmd[TIMER_SRC];
        // A timer DOWN/BAR is redundant while the same command still sits in the queue
        timer_dup = ((timer_cmd == DOWN) && (down_q != '0)) ||
                    ((timer_cmd == BAR)  && (bar_q  != '0));
        elig = '0;
        for (int i = 0; i < NSRC; i++) begin
            elig[i] = reset_n && !flush && req_valid[i] && (req_cmd[i] != NONE) &&
                      (room || ((i == TIMER_SRC) && timer_dup));
        end
    end

    rr_arbiter #(
        .NSRC (NSRC),
        .PW   (PW)
    ) u_rr_arbiter (
        .req       (elig),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Resolve the grant into a push or a coalesced drop, and form per-source acks
    always_comb begin
        grant_cmd = req_cmd[grant_idx];
        coalesce  = grant_any && (grant_idx == PW'(TIMER_SRC)) && timer_dup;
        push      = grant_any && !coalesce;
        req_ready = '0;
        for (int i = 0; i < NSRC; i++) begin
            req_ready[i] = reset_n && !flush && req_valid[i] &&
                           ((req_cmd[i] == NONE) || grant[i]);
        end
    end

    // Next-state for FIFO storage, pointers, pending counters and the coalesce pulse
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        count_d     = count_q;
        down_d      = down_q;
        bar_d       = bar_q;
        coalesced_d = 1'b0;
        for (int i = 0; i < QSIZE; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (flush) begin
            for (int i = 0; i < QSIZE; i++) begin
                mem_d[i] = NONE;
            end
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
            down_d  = '0;
            bar_d   = '0;
        end else begin
            // Clear the popped slot before writing, so a full push+pop lands correctly
            if (pop) begin
                mem_d[rd_q] = NONE;
                rd_d        = rd_q + AW'(1);
                count_d     = count_d - CW'(1);
                if (head == DOWN) down_d = down_d - CW'(1);
                if (head == BAR)  bar_d  = bar_d - CW'(1);
            end
            if (push) begin
                mem_d[wr_q] = grant_cmd;
                wr_d        = wr_q + AW'(1);
                count_d     = count_d + CW'(1);
                if (grant_cmd == DOWN) down_d = down_d + CW'(1);
                if (grant_cmd == BAR)  bar_d  = bar_d + CW'(1);
            end
            if (grant_any) begin
                rr_ptr_d = (grant_idx == PW'(NSRC - 1)) ? '0 : grant_idx + PW'(1);
            end
            coalesced_d = coalesce;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            count_q     <= '0;
            down_q      <= '0;
            bar_q       <= '0;
            coalesced_q <= 1'b0;
            for (int i = 0; i < QSIZE; i++) begin
                mem_q[i] <= NONE;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            count_q     <= count_d;
            down_q      <= down_d;
            bar_q       <= bar_d;
            coalesced_q <= coalesced_d;
            for (int i = 0; i < QSIZE; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign control   = head;
    assign count     = count_q;
    assign coalesced = coalesced_q;

endmodule

// File: doc/cmd_arbiter.md
Name: cmd_arbiter

Overview:
Merges game-command requests from several independent producers into one ordered command stream for the game engine. Producers are the button/switch decoder, the UART key decoder and the gravity/bar timer. The block round-robins between producers and buffers accepted commands in a FIFO. It releases one command per engine WAIT cycle and coalesces redundant timer commands, so gravity ticks cannot pile up behind user input.

Parameters:
NSRC, 4, number of requesting sources (2..8)
QSIZE, 16, FIFO depth in commands (power of 2)
TIMER_SRC, 0, index of the source whose DOWN/BAR commands are coalesced

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
req_valid  in  NSRC  per-source request valid
req_cmd  in  NSRC x state_type  per-source command, packed, index i = source i
req_ready  out  NSRC  per-source accept; a transfer occurs when req_valid[i] & req_ready[i] at a clk edge
state  in  state_type  current engine state; WAIT means the engine consumes a command this cycle
flush  in  1  clear all pending commands (game over / restart)
control  out  state_type  head of FIFO; NONE when empty
count  out  $clog2(QSIZE)+1  number of queued commands
coalesced  out  1  one-cycle pulse when a timer command is acknowledged but dropped

Behaviour:
- Reset (reset_n=0 at clk edge):
  - count=0, all FIFO entries NONE, control=NONE, coalesced=0.
  - Round-robin pointer=0, pending DOWN/BAR counters=0.
  - req_ready=0 combinationally while reset_n=0.
- NONE requests: req_valid with req_cmd==NONE is acknowledged (ready=1) without arbitration and without a push. It does not block other sources.
- Arbitration: among valid non-NONE requests, grant exactly one per cycle.
  - Search is round-robin, starting at pointer.
  - After a grant to source g, pointer <= (g+1) mod NSRC. The pointer is unchanged when there is no grant.
  - req_ready is combinational from req_valid, pointer, count, state and flush.
- Pop: at a clk edge with state==WAIT and count>0, the head is removed and the next entry becomes control on the following cycle.
- Push: the granted command is written at the tail.
  - Push and pop in the same cycle leave count unchanged.
  - Push into an empty FIFO: control shows the command the cycle after acceptance. It is never popped in its acceptance cycle.
- Full: when count==QSIZE, grant only if a pop occurs this cycle (state==WAIT). Otherwise all non-NONE ready=0 and requests hold.
- Coalescing:
  - Applies when the granted source is TIMER_SRC with DOWN while a DOWN is already pending, or with BAR while a BAR is already pending.
  - The request is acknowledged, nothing is pushed, and coalesced=1 for one cycle.
  - Pending counters increment on push of DOWN/BAR and decrement on pop of DOWN/BAR. Both may occur in the same cycle (net 0).
  - DOWN/BAR from other sources are always pushed; they still update the counters.
  - A coalesced drop is allowed even when the FIFO is full.
- flush=1 at a clk edge:
  - count=0, entries=NONE, pending counters=0; the pointer is kept.
  - All req_ready=0 in that cycle; no push, no pop.
  - flush overrides push/pop; reset overrides flush.
- Width rules: count never exceeds QSIZE and never underflows. Pointer width is $clog2(NSRC) with explicit wrap.

Decomposition:
- Package enum_type: state_type (NONE, INIT, WAIT, DOWN, BAR, LEFT, RIGHT, ROTATE, ROTATE_REV, DROP, HOLD, END), reused unchanged.
- Sub-module rr_arbiter:
  - Inputs: NSRC-bit request vector, pointer.
  - Outputs: one-hot grant, grant index.
  - Purely combinational.
- FIFO storage, pointer, pending counters and coalescing live in cmd_arbiter.

Test Plan:
- Reset, then source 2 sends LEFT with state!=WAIT -> ready[2]=1 that cycle, count=1, control=LEFT next cycle. Pulse state=WAIT one cycle -> control=NONE, count=0.
- Sources 1,2,3 hold RIGHT/ROTATE/DROP for 3 cycles, pointer=0 -> grants in order 1,2,3. FIFO order RIGHT, ROTATE, DROP; pointer=0 afterwards.
- Source 0 sends DOWN, then DOWN again with no pop -> second acknowledged, coalesced=1, count=1. After WAIT pops it, a third DOWN is pushed (count=1).
- Fill 16 HOLD commands from source 1 -> ready[1]=0 on the 17th. Same cycle state=WAIT -> accepted, count stays 16.
- Queue 5 commands, assert flush with state=WAIT and source 2 valid -> count=0, control=NONE, ready all 0 that cycle.
- Source 3 sends NONE while source 1 sends BAR -> both ready=1, only BAR pushed, count=1.
